pmem_loader: RTL and testbench

PMEM_LOADER -- requirements
Module: pmem_loader

---
 rtl/pmem_loader.sv | 155 +++++++++++++++
 tb/tb_pmem_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pmem_loader.sv
// Streaming program-memory loader: parses a counted, XOR-checksummed byte frame,
// writes 16-bit words into program memory and releases the core on a clean load.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | one-cycle settle after reset release
// CNT_HI  | waiting for word-count high byte
// CNT_LO  | waiting for word-count low byte; range-checks N
// DATA_HI | waiting for instruction high byte
// DATA_LO | waiting for instruction low byte; issues the memory write
// CHECK   | waiting for checksum byte
// RUN     | frame accepted, core released (terminal)
// ERROR   | frame rejected (terminal)
module pmem_loader #(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int PMEM_NUM_WORDS  = 2048,
    parameter int PC_INCREMENT    = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [7:0]                 in_byte,
    output logic                       out_ready,
    output logic                       out_pmem_we,
    output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
    output logic [PMEM_WORD_WIDTH-1:0] out_pmem_word,
    output logic                       out_core_reset,
    output logic                       out_done,
    output logic                       out_error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CNT_HI  = 3'd1,
        S_CNT_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CHECK   = 3'd5,
        S_RUN     = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [16:0]                MAX_WORDS = 17'(PMEM_NUM_WORDS);
    localparam logic [PMEM_ADDR_WIDTH-1:0] ADDR_STEP = PMEM_ADDR_WIDTH'(PC_INCREMENT);

    state_t                     r_state;
    logic [15:0]                r_count;
    logic [15:0]                r_index;
    logic [7:0]                 r_hi;
    logic [7:0]                 r_csum;
    logic [PMEM_ADDR_WIDTH-1:0] r_addr;

    logic        w_accept;
    logic [15:0] w_count;
    logic [15:0] w_index_nxt;
    logic [7:0]  w_csum_nxt;

    assign w_accept    = in_valid & out_ready;
    assign w_count     = {r_count[15:8], in_byte};
    assign w_index_nxt = r_index + 16'd1;
    assign w_csum_nxt  = r_csum ^ in_byte;

    // out_ready is registered, so every transition sets it for the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_index        <= '0;
            r_hi           <= '0;
            r_csum         <= '0;
            r_addr         <= '0;
            out_ready      <= 1'b0;
            out_pmem_we    <= 1'b0;
            out_pmem_addr  <= '0;
            out_pmem_word  <= '0;
            out_core_reset <= 1'b1;
            out_done       <= 1'b0;
            out_error      <= 1'b0;
        end else begin
            out_pmem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state   <= S_CNT_HI;
                    out_ready <= 1'b1;
                end
                S_CNT_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= in_byte;
                        r_csum        <= w_csum_nxt;
                        r_state       <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (w_accept) begin
                        r_count <= w_count;
                        r_csum  <= w_csum_nxt;
                        r_index <= '0;
                        r_addr  <= '0;
                        if (w_count == 16'd0) begin
                            r_state <= S_CHECK;
                        end else if ({1'b0, w_count} > MAX_WORDS) begin
                            r_state   <= S_ERROR;
                            out_ready <= 1'b0;
                            out_error <= 1'b1;
                        end else begin
                            r_state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (w_accept) begin
                        r_hi    <= in_byte;
                        r_csum  <= w_csum_nxt;
                        r_state <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (w_accept) begin
                        out_pmem_we   <= 1'b1;
                        out_pmem_addr <= r_addr;
                        out_pmem_word <= PMEM_WORD_WIDTH'({r_hi, in_byte});
                        r_addr        <= r_addr + ADDR_STEP;
                        r_index       <= w_index_nxt;
                        r_csum        <= w_csum_nxt;
                        r_state       <= (w_index_nxt == r_count) ? S_CHECK : S_DATA_HI;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        out_ready <= 1'b0;
                        r_csum    <= w_csum_nxt;
                        if (w_csum_nxt == 8'h00) begin
                            r_state        <= S_RUN;
                            out_core_reset <= 1'b0;
                            out_done       <= 1'b1;
                        end else begin
                            r_state   <= S_ERROR;
                            out_error <= 1'b1;
                        end
                    end
                end
                S_RUN, S_ERROR: begin
                    out_ready <= 1'b0;
                end
                default: begin
                    r_state   <= S_ERROR;
                    out_ready <= 1'b0;
                    out_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: frames, checksum errors, oversize count,
// stalls, and mid-frame reset, with hand-computed expected writes.
module tb_pmem_loader;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        out_ready;
    logic        out_pmem_we;
    logic [11:0] out_pmem_addr;
    logic [15:0] out_pmem_word;
    logic        out_core_reset;
    logic        out_done;
    logic        out_error;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] wa[$];
    logic [15:0] wd[$];

    pmem_loader dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_byte        (in_byte),
        .out_ready      (out_ready),
        .out_pmem_we    (out_pmem_we),
        .out_pmem_addr  (out_pmem_addr),
        .out_pmem_word  (out_pmem_word),
        .out_core_reset (out_core_reset),
        .out_done       (out_done),
        .out_error      (out_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Each write strobe is one cycle wide, so exactly one falling edge sees it.
    always @(negedge clock) begin
        if (out_pmem_we) begin
            wa.push_back(out_pmem_addr);
            wd.push_back(out_pmem_word);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"},   32'(out_ready),      32'h0);
        check({tag, ".we"},      32'(out_pmem_we),    32'h0);
        check({tag, ".addr"},    32'(out_pmem_addr),  32'h0);
        check({tag, ".word"},    32'(out_pmem_word),  32'h0);
        check({tag, ".corerst"}, 32'(out_core_reset), 32'h1);
        check({tag, ".done"},    32'(out_done),       32'h0);
        check({tag, ".error"},   32'(out_error),      32'h0);
    endtask

    // Called at a falling edge with reset high; leaves the DUT in CNT_HI.
    task automatic release_reset(input string tag);
        reset = 1'b0;
        check({tag, ".idle_ready"}, 32'(out_ready), 32'h0);
        @(negedge clock);
        check({tag, ".cnthi_ready"}, 32'(out_ready), 32'h1);
        wa.delete();
        wd.delete();
    endtask

    task automatic apply_reset(input string tag);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check_reset_outputs(tag);
        release_reset(tag);
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clock);
        in_valid = 1'b0;
        in_byte  = 8'hxx;
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, ".nwr"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check({tag, ".a0"}, 32'(wa[0]), 32'h000);
            check({tag, ".d0"}, 32'(wd[0]), 32'h1234);
            check({tag, ".a1"}, 32'(wa[1]), 32'h002);
            check({tag, ".d1"}, 32'(wd[1]), 32'hABCD);
        end
    endtask

    logic [7:0] frame_a[7] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;

        // Good two-word frame, back to back
        apply_reset("t1");
        for (int i = 0; i < 7; i++) begin
            if (i == 5) check("t1.ready_mid", 32'(out_ready), 32'h1);
            send(frame_a[i]);
        end
        check("t1.done",    32'(out_done),       32'h1);
        check("t1.corerst", 32'(out_core_reset), 32'h0);
        check("t1.ready",   32'(out_ready),      32'h0);
        check("t1.error",   32'(out_error),      32'h0);
        repeat (2) @(negedge clock);
        check_two_writes("t1");

        // Bad checksum: writes stay, error raised, core held
        apply_reset("t2");
        for (int i = 0; i < 6; i++) send(frame_a[i]);
        send(8'h43);
        check("t2.error",   32'(out_error),      32'h1);
        check("t2.corerst", 32'(out_core_reset), 32'h1);
        check("t2.done",    32'(out_done),       32'h0);
        check("t2.ready",   32'(out_ready),      32'h0);
        repeat (2) @(negedge clock);
        check_two_writes("t2");

        // Empty frame
        apply_reset("t3");
        send(8'h00);
        send(8'h00);
        check("t3.pre_done", 32'(out_done), 32'h0);
        send(8'h00);
        check("t3.done",    32'(out_done),       32'h1);
        check("t3.corerst", 32'(out_core_reset), 32'h0);
        check("t3.error",   32'(out_error),      32'h0);
        repeat (2) @(negedge clock);
        check("t3.nwr", 32'(wa.size()), 32'd0);

        // Count 2049 exceeds limit
        apply_reset("t4");
        send(8'h08);
        send(8'h01);
        check("t4.error", 32'(out_error), 32'h1);
        check("t4.ready", 32'(out_ready), 32'h0);
        check("t4.done",  32'(out_done),  32'h0);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)));
        check("t4.error_hold", 32'(out_error),      32'h1);
        check("t4.corerst",    32'(out_core_reset), 32'h1);
        check("t4.nwr",        32'(wa.size()),      32'd0);

        // Count 2048 is the limit and is accepted
        apply_reset("t4b");
        send(8'h08);
        send(8'h00);
        check("t4b.error", 32'(out_error), 32'h0);
        check("t4b.ready", 32'(out_ready), 32'h1);

        // Random stalls, then extra bytes after RUN
        apply_reset("t5");
        for (int i = 0; i < 7; i++) begin
            int gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) begin
                in_byte = 8'($urandom_range(0, 255));
                @(negedge clock);
            end
            if (i == 4) check("t5.ready_gap", 32'(out_ready), 32'h1);
            send(frame_a[i]);
        end
        check("t5.done",    32'(out_done),       32'h1);
        check("t5.corerst", 32'(out_core_reset), 32'h0);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)));
        check("t5.done_hold", 32'(out_done),  32'h1);
        check("t5.error",     32'(out_error), 32'h0);
        repeat (2) @(negedge clock);
        check_two_writes("t5");

        // Reset mid-frame, then a full frame restarts at address 0
        apply_reset("t6");
        send(8'h00);
        send(8'h02);
        send(8'h12);
        reset = 1'b1;
        #1;
        check_reset_outputs("t6.async");
        @(negedge clock);
        check_reset_outputs("t6.held");
        release_reset("t6r");
        for (int i = 0; i < 7; i++) send(frame_a[i]);
        check("t6.done",    32'(out_done),       32'h1);
        check("t6.corerst", 32'(out_core_reset), 32'h0);
        repeat (2) @(negedge clock);
        check_two_writes("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
